// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared ROB widths, packed entry layout, commit record and FSM states.
package reorder_buffer_pkg;
  localparam int ROB_DEPTH = 32;
  localparam int ROB_TAG_W = 5;
  localparam int ROB_PREG_W = 6;
  typedef enum logic {RUN, FLUSH} rob_state_e;
  // Member order fixes the packed offsets: valid is bit 0, pc the top 32 bits.
  typedef struct packed {
    logic [31:0] pc;
    logic [ROB_PREG_W-1:0] old_preg;
    logic [ROB_PREG_W-1:0] new_preg;
    logic [4:0] arch_rd;
    logic regwrite;
    logic is_store;
    logic mispredict;
    logic [31:0] target;
    logic done;
    logic valid;
  } rob_entry_t;
  typedef struct packed {
    logic valid;
    logic [4:0] arch_rd;
    logic [ROB_PREG_W-1:0] new_preg;
    logic [ROB_PREG_W-1:0] free_preg;
    logic regwrite;
    logic store;
    logic [31:0] pc;
  } rob_commit_t;
  // Writes to x0 neither update the RRAT nor free a register.
  function automatic rob_commit_t retire(rob_entry_t e);
    logic rw;
    rw = e.regwrite && e.arch_rd != 5'd0;
    return '{valid: 1'b1, arch_rd: e.arch_rd, new_preg: e.new_preg,
             free_preg: rw ? e.old_preg : '0, regwrite: rw, store: e.is_store, pc: e.pc};
  endfunction
endpackage

// File: rtl/reorder_buffer_ptr.sv
// rob_ptr: wrapping ROB index with increment and synchronous clear.
module rob_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q, ptr_d;
  assign ptr_d = clr_i ? '0 : ptr_q + W'(inc_i);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
  assign ptr_o = ptr_q;
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer; commits the oldest done entry per cycle
// and flushes all younger state one cycle after a mispredicted branch retires.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = ROB_TAG_W,
  parameter int PREG_W = ROB_PREG_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic [4:0]        alloc_arch_rd,
  input  logic [PREG_W-1:0] alloc_new_preg,
  input  logic [PREG_W-1:0] alloc_old_preg,
  input  logic              alloc_regwrite,
  input  logic              alloc_is_store,
  input  logic [31:0]       alloc_pc,
  input  logic              cmpl_valid,
  input  logic [TAG_W-1:0]  cmpl_tag,
  input  logic              cmpl_mispredict,
  input  logic [31:0]       cmpl_target,
  output logic              commit_valid,
  output logic [4:0]        commit_arch_rd,
  output logic [PREG_W-1:0] commit_new_preg,
  output logic [PREG_W-1:0] commit_free_preg,
  output logic              commit_regwrite,
  output logic              commit_store,
  output logic [31:0]       commit_pc,
  output logic              flush,
  output logic [31:0]       flush_pc,
  output logic [TAG_W:0]    count
);
  rob_entry_t mem_q [DEPTH];
  rob_entry_t head_e;
  rob_state_e state_q, state_d;
  rob_commit_t commit_q, commit_d;
  logic [31:0] flush_pc_q, flush_pc_d;
  logic [TAG_W:0] count_q, count_d;
  logic [TAG_W-1:0] head, tail;
  logic do_alloc, do_cmpl, do_commit, flush_now;
  assign head_e    = mem_q[head];
  assign flush_now = state_q == FLUSH;
  assign alloc_ready = RESET && count_q != (TAG_W+1)'(DEPTH) && !flush_now;
  assign do_alloc  = alloc_valid && alloc_ready;
  assign do_cmpl   = !flush_now && cmpl_valid && mem_q[cmpl_tag].valid;
  assign do_commit = !flush_now && head_e.valid && head_e.done;
  rob_ptr #(.W(TAG_W)) u_head (.clk(CLK), .rst_n(RESET), .inc_i(do_commit), .clr_i(flush_now), .ptr_o(head));
  rob_ptr #(.W(TAG_W)) u_tail (.clk(CLK), .rst_n(RESET), .inc_i(do_alloc), .clr_i(flush_now), .ptr_o(tail));
  always_comb begin
    state_d    = (do_commit && head_e.mispredict) ? FLUSH : RUN;
    count_d    = flush_now ? '0 : count_q + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);
    commit_d   = do_commit ? retire(head_e) : '0;
    flush_pc_d = (state_d == FLUSH) ? head_e.target : '0;
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state_q    <= RUN;
      count_q    <= '0;
      commit_q   <= '0;
      flush_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      commit_q   <= commit_d;
      flush_pc_q <= flush_pc_d;
    end
  // A completion and a commit may hit the same entry; the commit's valid clear wins.
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_now) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i].valid <= 1'b0;
    end else begin
      if (do_cmpl) begin
        mem_q[cmpl_tag].done       <= 1'b1;
        mem_q[cmpl_tag].mispredict <= cmpl_mispredict;
        mem_q[cmpl_tag].target     <= cmpl_target;
      end
      if (do_commit) mem_q[head].valid <= 1'b0;
      if (do_alloc) mem_q[tail] <= '{pc: alloc_pc, old_preg: alloc_old_preg, new_preg: alloc_new_preg,
                                     arch_rd: alloc_arch_rd, regwrite: alloc_regwrite, is_store: alloc_is_store,
                                     mispredict: 1'b0, target: '0, done: 1'b0, valid: 1'b1};
    end
  assign alloc_tag        = tail;
  assign count            = count_q;
  assign flush            = flush_now;
  assign flush_pc         = flush_pc_q;
  assign commit_valid     = commit_q.valid;
  assign commit_arch_rd   = commit_q.arch_rd;
  assign commit_new_preg  = commit_q.new_preg;
  assign commit_free_preg = commit_q.free_preg;
  assign commit_regwrite  = commit_q.regwrite;
  assign commit_store     = commit_q.store;
  assign commit_pc        = commit_q.pc;
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer directly downstream of the rename stage.
- Rename allocates one entry per cycle carrying the destination mapping, old physical mapping, PC and control flags.
- Execute marks entries complete by tag. The ROB commits the oldest completed entry each cycle: it updates the RRAT and frees the old physical register.
- On a committed mispredicted branch it flushes all younger state and redirects fetch.

Parameters:
- DEPTH, 32, number of entries; must be a power of two.
- TAG_W, 5, log2(DEPTH); width of the entry index/tag.
- PREG_W, 6, physical register index width (64 physical registers).

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous active-low reset.
- alloc_valid  input  1  rename presents an entry this cycle.
- alloc_ready  output  1  ROB can accept an entry (not full, no flush pending).
- alloc_tag  output  TAG_W  index the presented entry will occupy (current tail).
- alloc_arch_rd  input  5  architectural destination register.
- alloc_new_preg  input  PREG_W  newly mapped physical destination.
- alloc_old_preg  input  PREG_W  previous mapping of alloc_arch_rd.
- alloc_regwrite  input  1  instruction writes a register.
- alloc_is_store  input  1  instruction is a store.
- alloc_pc  input  32  instruction PC.
- cmpl_valid  input  1  execute reports a completion.
- cmpl_tag  input  TAG_W  entry that completed.
- cmpl_mispredict  input  1  completed branch resolved opposite to fetch.
- cmpl_target  input  32  correct next PC for a mispredict.
- commit_valid  output  1  one entry retired this cycle.
- commit_arch_rd  output  5  RRAT index to update.
- commit_new_preg  output  PREG_W  RRAT new value.
- commit_free_preg  output  PREG_W  physical register returned to the free list.
- commit_regwrite  output  1  commit_arch_rd/new_preg valid for RRAT update.
- commit_store  output  1  LSQ may release the oldest store.
- commit_pc  output  32  PC of the retired instruction (debug/trace).
- flush  output  1  one-cycle pulse: squash all speculative state, copy RRAT into FRAT.
- flush_pc  output  32  redirect target valid with flush.
- count  output  TAG_W+1  occupied entries.

Behaviour:
- Reset (RESET low, asynchronous):
  - head=tail=0, count=0, all valid/done bits 0.
  - commit_* = 0, flush=0, flush_pc=0.
  - alloc_ready=1 once RESET deasserts.
- Allocation:
  - Occurs when alloc_valid && alloc_ready.
  - Writes the entry at tail, sets valid=1 and done=0, then advances tail by 1 mod DEPTH.
  - alloc_ready = (count != DEPTH) && !flush_pending. It is computed from registered state only; a same-cycle commit does not open a slot.
- Completion:
  - When cmpl_valid and entry[cmpl_tag].valid, set done=1 and latch mispredict/target.
  - Completion to an invalid entry is ignored.
  - The done bit is visible to commit the following cycle (no same-cycle bypass).
- Commit:
  - If entry[head].valid && entry[head].done, then on the next edge:
    - commit_valid=1 and the entry's fields drive commit_*;
    - commit_regwrite = regwrite && arch_rd != 0;
    - commit_free_preg = old_preg, valid only when commit_regwrite;
    - head advances and the entry's valid bit is cleared.
  - Otherwise commit_valid=0 and all commit_* fields are 0.
  - At most one commit per cycle.
- Simultaneous alloc and commit in one cycle: count unchanged; tail and head both advance.
- Pointer wrap: head and tail wrap DEPTH-1 -> 0. Full/empty is determined by count, not by pointer equality.
- Mispredict state machine, states RUN -> FLUSH -> RUN:
  - In RUN, committing an entry with mispredict=1 registers commit_* for that branch (the branch itself retires).
  - In the same edge, move to FLUSH with flush_pending=1.
  - In FLUSH, flush=1 and flush_pc=target for exactly one cycle.
  - In that cycle all valid bits clear, head=tail=0, count=0, and allocation and completion inputs are ignored.
  - Return to RUN the next cycle with flush=0.
- Reset mid-flush: returns to RUN with empty ROB; no flush pulse is emitted.
- count = entries valid; never exceeds DEPTH; never underflows.

Decomposition:
- Shared package/include (alongside config.v): ROB_DEPTH, ROB_TAG_W, PREG_W, and field offsets of the packed entry {pc, old_preg, new_preg, arch_rd, regwrite, is_store, mispredict, target, done, valid}.
- One natural sub-module: rob_ptr, a wrapping TAG_W-bit pointer with increment and synchronous clear, instantiated for head and tail.

Test Plan:
- Reset, then alloc 3 entries (tags 0,1,2, arch_rd 8/9/10), complete tag 1 then 0 then 2 -> commits in order 0,1,2 on cycles after each is done; count returns to 0.
- Alloc 32 entries, no completions -> alloc_ready=0 at count=32. Complete tag 0 -> one commit; alloc_ready returns to 1 only the cycle after count drops to 31.
- Alloc with arch_rd=0, regwrite=1, old_preg=5 -> commit_regwrite=0 and no free reported.
- Alloc tags 0-4, complete tag 1 with mispredict=1 and target 0x00400100, complete tag 0 -> tag 0 commits, then tag 1 commits. The next cycle flush=1, flush_pc=0x00400100; count=0 and alloc_tag=0 after the pulse; tags 2-4 never commit.
- Fill past index 31 by alloc/commit streaming 40 instructions -> tags wrap 31->0, commit order matches alloc order, and count never exceeds 32.
- Assert RESET low during the FLUSH cycle -> all outputs 0 immediately; after release count=0 and flush stays 0.
